kx_bus_arbiter: RTL and testbench
=================================

// Module: kx_bus_arbiter
// PURPOSE
//  N-master to 1-slave arbiter for the CPU simple-bus protocol (cmd valid/ready, rsp valid, in-order rsp).
//  Merges the CPU iBus and dBus plus DMA/debug masters onto one shared memory/peripheral port.
//  Tracks outstanding reads in an ID FIFO and routes each in-order response to its issuing master.
// PARAMETERS
//  NUM_MASTERS  2   number of masters, 1..8; master 0 = CPU iBus, master 1 = CPU dBus
//  ADDR_W       32  address width
//  DATA_W       32  data width; mask width = DATA_W/8
//  MAX_PENDING  4   max outstanding reads, power of 2, >= 2
// PORTS
//  clk           in   1                 single clock, all logic on rising edge
//  reset         in   1                 synchronous, active-high
//  m_cmd_valid   in   NUM_MASTERS       per-master command valid
//  m_cmd_ready   out  NUM_MASTERS       per-master command accepted
//  m_cmd_wr      in   NUM_MASTERS       1 = write (no rsp), 0 = read (one rsp)
//  m_cmd_mask    in   NUM_MASTERS*DATA_W/8  byte enables, master i at slice i
//  m_cmd_addr    in   NUM_MASTERS*ADDR_W    byte address, master i at slice i
//  m_cmd_data    in   NUM_MASTERS*DATA_W    write data, master i at slice i
//  m_rsp_valid   out  NUM_MASTERS       one-hot response strobe
//  m_rsp_data    out  DATA_W            read data, broadcast to all masters
//  m_rsp_error   out  1                 bus error, qualified by m_rsp_valid
//  s_cmd_valid/s_cmd_ready/s_cmd_wr/s_cmd_mask/s_cmd_addr/s_cmd_data  out/in/out/out/out/out  slave cmd
//  s_rsp_valid   in   1 ; s_rsp_data in DATA_W ; s_rsp_error in 1   in-order slave responses
//  pending_cnt   out  $clog2(MAX_PENDING)+1  outstanding reads
//  err_orphan    out  1                 sticky: s_rsp_valid seen with no read outstanding
// BEHAVIOUR
//  - Reset: s_cmd_valid=0, m_cmd_ready=0, m_rsp_valid=0, pending_cnt=0, err_orphan=0, RR pointer=0, lock=0.
//  - Cmd path is zero-latency combinational: selected master's payload drives s_cmd_*; m_cmd_ready[g]=s_cmd_ready&s_cmd_valid.
//  - Arbitration when unlocked: round-robin, search starts at rr_ptr; winner g.
//  - Lock: if s_cmd_valid&!s_cmd_ready, register g and lock=1; grant and payload held until accept (valid-hold rule).
//  - On accept: lock=0, rr_ptr=(g+1) mod NUM_MASTERS (wrap at NUM_MASTERS-1 -> 0).
//  - Read gating: s_cmd_valid = sel_valid & !(~sel_wr & full), full from registered count; a pop in the same
//    cycle does NOT lift the gate. Writes are never gated. Gate cannot newly assert while locked (pushes only on accept).
//  - Read accept pushes g into ID FIFO; s_rsp_valid pops head h: m_rsp_valid=(1<<h), data/error pass through same cycle.
//  - Simultaneous push+pop: count unchanged, both FIFO pointers advance.
//  - s_rsp_valid with FIFO empty: dropped, no m_rsp_valid, err_orphan<=1 until reset.
//  - Masters must hold cmd until ready; a master dropping valid while locked is a protocol violation (undefined).
//  - Reset mid-transaction: FIFO, lock and counters cleared; in-flight responses then count as orphans.
// CONFIGURATION
//  - KX_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, rr_ptr removed; lock rule unchanged.
//  - Undefined (default): round-robin as above.
// STRUCTURE
//  - kx_bus_pkg: MAX_MASTERS=8, id-width function clog2_min1(), simple-bus slice index helpers.
//  - Sub-module kx_id_fifo: sync FIFO, DEPTH=MAX_PENDING, width=clog2_min1(NUM_MASTERS), count/full/empty outputs.
//  - Top: arbiter, lock register, payload mux, response demux.
// TESTING
//  - Reset: hold reset 3 cycles, all masters valid -> all outputs 0 while reset high; grant master 0 first cycle after.
//  - RR fairness: N=3, all valid, s_cmd_ready=1, writes -> grant order 0,1,2,0,1,2; no m_rsp_valid.
//  - Valid-hold: m1 read @0x100, m0 valid next cycle, s_cmd_ready=0 for 5 cycles -> s_cmd_addr stays 0x100, m1 accepted first.
//  - Full gating: MAX_PENDING=4, 4 reads accepted, no rsp -> 5th read s_cmd_valid=0, write from other master still passes;
//    one rsp -> 5th read issues next cycle.
//  - Routing: reads m1,m0,m1 then rsp 0xA,0xB,0xC (0xB error=1) -> m_rsp_valid 0b10,0b01,0b10, error only on 2nd.
//  - Orphan: s_rsp_valid with pending_cnt=0 -> no m_rsp_valid, err_orphan=1 until reset; rerun order test under KX_ARB_FIXED_PRIO_EN -> 0,0,0.

Source files
------------

// File: rtl/kx_bus_pkg.sv
// Shared simple-bus definitions: master limits, id-width helper, slice index helpers.
// Combinational helpers only; no storage or flow control of its own.
package kx_bus_pkg;

  localparam int MAX_MASTERS = 8;

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arbState_t;

  // Width of a master id; never zero so a single-master build still has a legal vector.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int sliceLo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/kx_id_fifo.sv
// Synchronous id FIFO recording which master issued each outstanding read; head is visible combinationally.
// Push is ignored when full and pop ignored when empty; the arbiter gates reads so neither should occur.
import kx_bus_pkg::*;

module kx_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pushValid,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     popValid,
  output logic [WIDTH-1:0]         popData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign doPush  = pushValid & ~full;
  assign doPop   = popValid & ~empty;
  assign popData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (doPush && !doPop) begin
        count <= count + 1'b1;
      end else if (!doPush && doPop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/kx_bus_arbiter.sv
// N-master simple-bus arbiter: zero-latency cmd mux, in-order rsp routed by id FIFO; KX_ARB_FIXED_PRIO_EN selects fixed priority.
// A stalled grant locks until accepted; reads stall while MAX_PENDING reads are outstanding, writes never do.
import kx_bus_pkg::*;

module kx_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            m_cmd_valid,
  output logic [NUM_MASTERS-1:0]            m_cmd_ready,
  input  logic [NUM_MASTERS-1:0]            m_cmd_wr,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_cmd_mask,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     m_cmd_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]     m_cmd_data,
  output logic [NUM_MASTERS-1:0]            m_rsp_valid,
  output logic [DATA_W-1:0]                 m_rsp_data,
  output logic                              m_rsp_error,
  output logic                              s_cmd_valid,
  input  logic                              s_cmd_ready,
  output logic                              s_cmd_wr,
  output logic [DATA_W/8-1:0]               s_cmd_mask,
  output logic [ADDR_W-1:0]                 s_cmd_addr,
  output logic [DATA_W-1:0]                 s_cmd_data,
  input  logic                              s_rsp_valid,
  input  logic [DATA_W-1:0]                 s_rsp_data,
  input  logic                              s_rsp_error,
  output logic [$clog2(MAX_PENDING):0]      pending_cnt,
  output logic                              err_orphan
);

  localparam int ID_W   = clog2_min1(NUM_MASTERS);
  localparam int MASK_W = DATA_W / 8;

  arbState_t       state;
  logic [ID_W-1:0] lockGrant;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] headId;
  logic            selValid;
  logic            selWr;
  logic            accept;
  logic            push;
  logic            pop;
  logic            idFull;
  logic            idEmpty;

`ifdef KX_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (m_cmd_valid[i]) begin
        winner = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] rrPtr;

  always_comb begin
    int  idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = (int'(rrPtr) + i) % NUM_MASTERS;
      if (!found && m_cmd_valid[idx]) begin
        winner = ID_W'(idx);
        found  = 1'b1;
      end
    end
  end
`endif

  assign grant = (state == ARB_LOCKED) ? lockGrant : winner;

  always_comb begin
    selValid   = 1'b0;
    selWr      = 1'b0;
    s_cmd_mask = '0;
    s_cmd_addr = '0;
    s_cmd_data = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant == ID_W'(i)) begin
        selValid   = m_cmd_valid[i];
        selWr      = m_cmd_wr[i];
        s_cmd_mask = m_cmd_mask[sliceLo(i, MASK_W) +: MASK_W];
        s_cmd_addr = m_cmd_addr[sliceLo(i, ADDR_W) +: ADDR_W];
        s_cmd_data = m_cmd_data[sliceLo(i, DATA_W) +: DATA_W];
      end
    end
  end

  // Full is taken from the registered count, so a same-cycle pop does not reopen the gate.
  assign s_cmd_valid = ~reset & selValid & ~(~selWr & idFull);
  assign s_cmd_wr    = selWr;
  assign accept      = s_cmd_valid & s_cmd_ready;
  assign push        = accept & ~selWr;
  assign pop         = s_rsp_valid & ~reset & ~idEmpty;
  assign m_rsp_data  = s_rsp_data;
  assign m_rsp_error = s_rsp_error;

  always_comb begin
    m_cmd_ready = '0;
    m_rsp_valid = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_cmd_ready[i] = accept && (grant == ID_W'(i));
      m_rsp_valid[i] = pop && (headId == ID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_OPEN;
      lockGrant  <= '0;
      err_orphan <= 1'b0;
`ifndef KX_ARB_FIXED_PRIO_EN
      rrPtr      <= '0;
`endif
    end else begin
      if (accept) begin
        state <= ARB_OPEN;
`ifndef KX_ARB_FIXED_PRIO_EN
        rrPtr <= (grant == ID_W'(NUM_MASTERS - 1)) ? '0 : grant + 1'b1;
`endif
      end else if (s_cmd_valid) begin
        state     <= ARB_LOCKED;
        lockGrant <= grant;
      end
      if (s_rsp_valid && idEmpty) begin
        err_orphan <= 1'b1;
      end
    end
  end

  kx_id_fifo #(
    .DEPTH (MAX_PENDING),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk       (clk),
    .reset     (reset),
    .pushValid (push),
    .pushData  (grant),
    .popValid  (pop),
    .popData   (headId),
    .count     (pending_cnt),
    .full      (idFull),
    .empty     (idEmpty)
  );

endmodule

// File: tb/tb_kx_bus_arbiter.sv
// Directed bench for kx_bus_arbiter: table of single-cycle vectors plus hand sequences for lock, full gating and orphans.
// Builds in either arbitration mode; expected grant order follows KX_ARB_FIXED_PRIO_EN.
module tb_kx_bus_arbiter;

  localparam int NM = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NM-1:0] mValid;
  logic [NM-1:0] mReady;
  logic [NM-1:0] mWr;
  logic [11:0]   mMask;
  logic [95:0]   mAddr;
  logic [95:0]   mData;
  logic [NM-1:0] mRspValid;
  logic [31:0]   mRspData;
  logic          mRspError;
  logic          sValid;
  logic          sReady;
  logic          sWr;
  logic [3:0]    sMask;
  logic [31:0]   sAddr;
  logic [31:0]   sData;
  logic          sRspValid;
  logic [31:0]   sRspData;
  logic          sRspError;
  logic [2:0]    pendingCnt;
  logic          errOrphan;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  kx_bus_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_W      (32),
    .DATA_W      (32),
    .MAX_PENDING (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m_cmd_valid (mValid),
    .m_cmd_ready (mReady),
    .m_cmd_wr    (mWr),
    .m_cmd_mask  (mMask),
    .m_cmd_addr  (mAddr),
    .m_cmd_data  (mData),
    .m_rsp_valid (mRspValid),
    .m_rsp_data  (mRspData),
    .m_rsp_error (mRspError),
    .s_cmd_valid (sValid),
    .s_cmd_ready (sReady),
    .s_cmd_wr    (sWr),
    .s_cmd_mask  (sMask),
    .s_cmd_addr  (sAddr),
    .s_cmd_data  (sData),
    .s_rsp_valid (sRspValid),
    .s_rsp_data  (sRspData),
    .s_rsp_error (sRspError),
    .pending_cnt (pendingCnt),
    .err_orphan  (errOrphan)
  );

  typedef struct {
    string      name;
    logic [2:0] valid;
    logic [2:0] wr;
    logic       ready;
    logic       rsp;
    logic [31:0] rspData;
    logic       rspErr;
    logic       expSValid;
    logic [2:0] expReady;
    logic [2:0] expRsp;
    logic [2:0] expPend;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0] w, input logic rdy,
                       input logic rsp, input logic [31:0] d, input logic e);
    mValid    = v;
    mWr       = w;
    sReady    = rdy;
    sRspValid = rsp;
    sRspData  = d;
    sRspError = e;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string n, input logic [2:0] v, input logic [2:0] w, input logic rdy,
                              input logic rsp, input logic [31:0] d, input logic e, input logic es,
                              input logic [2:0] er, input logic [2:0] ersp, input logic [2:0] ep);
    vec_t r;
    r.name = n; r.valid = v; r.wr = w; r.ready = rdy; r.rsp = rsp; r.rspData = d; r.rspErr = e;
    r.expSValid = es; r.expReady = er; r.expRsp = ersp; r.expPend = ep;
    return r;
  endfunction

  initial begin
    logic [2:0] rrOrder [6];
`ifdef KX_ARB_FIXED_PRIO_EN
    rrOrder = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
    rrOrder = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
    for (int i = 0; i < 6; i++) begin
      vecs[i] = mk($sformatf("rr_write_%0d", i), 3'b111, 3'b111, 1'b1, 1'b0, 32'h0, 1'b0,
                   1'b1, rrOrder[i], 3'b000, 3'd0);
    end
    vecs[6]  = mk("rd_m1",   3'b010, 3'b000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 3'b010, 3'b000, 3'd0);
    vecs[7]  = mk("rd_m0",   3'b001, 3'b000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 3'b001, 3'b000, 3'd1);
    vecs[8]  = mk("rd_m1b",  3'b010, 3'b000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 3'b010, 3'b000, 3'd2);
    vecs[9]  = mk("rsp_A",   3'b000, 3'b000, 1'b1, 1'b1, 32'hA, 1'b0, 1'b0, 3'b000, 3'b010, 3'd3);
    vecs[10] = mk("rsp_B",   3'b000, 3'b000, 1'b1, 1'b1, 32'hB, 1'b1, 1'b0, 3'b000, 3'b001, 3'd2);
    vecs[11] = mk("rsp_C",   3'b000, 3'b000, 1'b1, 1'b1, 32'hC, 1'b0, 1'b0, 3'b000, 3'b010, 3'd1);
    vecs[12] = mk("idle",    3'b000, 3'b000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 3'b000, 3'd0);

    mAddr = {32'h0000_0300, 32'h0000_0100, 32'h0000_0200};
    mData = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    mMask = {4'hC, 4'h3, 4'hF};

    // Reset held three cycles with every master requesting.
    reset = 1'b1;
    drive(3'b111, 3'b111, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst_svalid_%0d", c), 32'(sValid), 32'd0);
      check($sformatf("rst_ready_%0d", c), 32'(mReady), 32'd0);
      check($sformatf("rst_rsp_%0d", c), 32'(mRspValid), 32'd0);
      check($sformatf("rst_pend_%0d", c), 32'(pendingCnt), 32'd0);
      check($sformatf("rst_orphan_%0d", c), 32'(errOrphan), 32'd0);
      nextCycle();
    end
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].wr, vecs[i].ready, vecs[i].rsp, vecs[i].rspData, vecs[i].rspErr);
      @(negedge clk);
      check({vecs[i].name, "_svalid"}, 32'(sValid), 32'(vecs[i].expSValid));
      check({vecs[i].name, "_ready"}, 32'(mReady), 32'(vecs[i].expReady));
      check({vecs[i].name, "_rsp"}, 32'(mRspValid), 32'(vecs[i].expRsp));
      check({vecs[i].name, "_pend"}, 32'(pendingCnt), 32'(vecs[i].expPend));
      if (vecs[i].rsp) begin
        check({vecs[i].name, "_err"}, 32'(mRspError), 32'(vecs[i].rspErr));
        check({vecs[i].name, "_data"}, mRspData, vecs[i].rspData);
      end
      nextCycle();
    end

    // Valid-hold: m1 read stalls five cycles while m0 also requests.
    drive(3'b010, 3'b001, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("hold_svalid", 32'(sValid), 32'd1);
    check("hold_addr_0", sAddr, 32'h100);
    check("hold_ready_0", 32'(mReady), 32'd0);
    nextCycle();
    for (int c = 1; c < 5; c++) begin
      drive(3'b011, 3'b001, 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      check($sformatf("hold_addr_%0d", c), sAddr, 32'h100);
      check($sformatf("hold_wr_%0d", c), 32'(sWr), 32'd0);
      check($sformatf("hold_ready_%0d", c), 32'(mReady), 32'd0);
      nextCycle();
    end
    drive(3'b011, 3'b001, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("hold_accept_m1", 32'(mReady), 32'b010);
    check("hold_accept_addr", sAddr, 32'h100);
    check("hold_accept_data", sData, 32'hBBBB_0001);
    check("hold_accept_mask", 32'(sMask), 32'h3);
    nextCycle();
    drive(3'b001, 3'b001, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("hold_then_m0", 32'(mReady), 32'b001);
    check("hold_m0_addr", sAddr, 32'h200);
    check("hold_m0_wr", 32'(sWr), 32'd1);
    check("hold_pend", 32'(pendingCnt), 32'd1);
    nextCycle();
    drive(3'b000, 3'b000, 1'b1, 1'b1, 32'h55, 1'b0);
    @(negedge clk);
    check("hold_rsp_m1", 32'(mRspValid), 32'b010);
    nextCycle();

    // Full gating: four reads outstanding block a fifth until a response is seen.
    for (int k = 0; k < 4; k++) begin
      drive(3'b001, 3'b000, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      check($sformatf("fill_ready_%0d", k), 32'(mReady), 32'b001);
      check($sformatf("fill_pend_%0d", k), 32'(pendingCnt), 32'(k));
      nextCycle();
    end
    drive(3'b001, 3'b000, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("full_rd_gated", 32'(sValid), 32'd0);
    check("full_rd_ready", 32'(mReady), 32'd0);
    check("full_pend", 32'(pendingCnt), 32'd4);
    nextCycle();
    drive(3'b100, 3'b100, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("full_wr_svalid", 32'(sValid), 32'd1);
    check("full_wr_ready", 32'(mReady), 32'b100);
    nextCycle();
    drive(3'b001, 3'b100, 1'b1, 1'b1, 32'h1, 1'b0);
    @(negedge clk);
    check("full_pop_still_gated", 32'(sValid), 32'd0);
    check("full_pop_rsp", 32'(mRspValid), 32'b001);
    check("full_pop_pend", 32'(pendingCnt), 32'd4);
    nextCycle();
    drive(3'b001, 3'b100, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("full_rd_released", 32'(sValid), 32'd1);
    check("full_rd_accept", 32'(mReady), 32'b001);
    check("full_rel_pend", 32'(pendingCnt), 32'd3);
    nextCycle();
    for (int k = 0; k < 4; k++) begin
      drive(3'b000, 3'b000, 1'b1, 1'b1, 32'h10 + 32'(k), 1'b0);
      @(negedge clk);
      check($sformatf("drain_rsp_%0d", k), 32'(mRspValid), 32'b001);
      check($sformatf("drain_pend_%0d", k), 32'(pendingCnt), 32'(4 - k));
      nextCycle();
    end

    // Orphan response with nothing outstanding.
    drive(3'b000, 3'b000, 1'b1, 1'b1, 32'hDEAD, 1'b0);
    @(negedge clk);
    check("orphan_pend", 32'(pendingCnt), 32'd0);
    check("orphan_no_rsp", 32'(mRspValid), 32'd0);
    check("orphan_pre", 32'(errOrphan), 32'd0);
    nextCycle();
    drive(3'b000, 3'b000, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("orphan_sticky_%0d", c), 32'(errOrphan), 32'd1);
      nextCycle();
    end
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    check("orphan_cleared", 32'(errOrphan), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
